// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging N DII channels onto one ring
// injection channel through a one-entry registered output stage.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_data/in_last/
//   in_valid/in_ready      N requester channels (requester i at slice i)
//   out_data/out_last/
//   out_valid/out_ready    registered output channel to the debug ring
//   busy                   a multi-flit packet currently holds the lock
//   cur_grant              locked requester, or last granted one when idle
module dii_packet_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDXW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [IDXW-1:0]    cur_grant
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   last_grant;
    logic [IDXW-1:0]   last_grant_next;
    logic [IDXW-1:0]   lock_idx;
    logic [IDXW-1:0]   lock_idx_next;

    logic              accept;
    logic              xfer;
    logic [IDXW-1:0]   sel;
    logic              sel_valid;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    // Output register can take a new flit when empty or being drained.
    assign accept = !out_valid || out_ready;
    assign xfer   = accept && sel_valid;

    // Requester selection: locked owner, else round-robin after last_grant.
    // The loop runs from lowest to highest priority so the nearest valid
    // requester after the pointer is the final assignment.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        if (state == LOCKED) begin
            sel       = lock_idx;
            sel_valid = in_valid[lock_idx];
        end else begin
            for (int k = int'(N); k >= 1; k--) begin
                if (in_valid[IDXW'((int'(last_grant) + k) % int'(N))]) begin
                    sel       = IDXW'((int'(last_grant) + k) % int'(N));
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Payload mux and one-hot ready back to the selected requester.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel == IDXW'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_last    = in_last[i];
                in_ready[i] = xfer;
            end
        end
    end

    // Next-state: lock on a non-last first flit, release on the last flit.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        lock_idx_next   = lock_idx;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (sel_last) begin
                        last_grant_next = sel;
                    end else begin
                        state_next    = LOCKED;
                        lock_idx_next = sel;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_next      = IDLE;
                        last_grant_next = lock_idx;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, pointer and output pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDXW'(N - 1);
            lock_idx   <= '0;
            busy       <= 1'b0;
            cur_grant  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            lock_idx   <= lock_idx_next;
            busy       <= (state_next == LOCKED);
            if (xfer) begin
                cur_grant <= sel;
            end
            if (accept) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_last <= sel_last;
                end
            end
        end
    end

endmodule
